// File: rtl/leaky_relu_inv_stream.sv
// leaky_relu_inv_stream
//   Streaming inverse leaky ReLU. It recovers the pre-activation x from an
//   activated y, one element per cycle, over a B*C*H*W tensor.
//   - y >= 0 : x = y
//   - y <  0 : x = (y * INV_SLOPE) >>> FRAC_WIDTH, saturated at the most
//              negative DATA_WIDTH value
//   The block also tracks frame position. The last element of every N-element
//   frame is tagged on out_last, and a frame_err pulse is raised when the
//   upstream in_last disagrees with that position.
//
// Ports
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      input handshake
//   in_data                activated element y (signed)
//   in_last                upstream end-of-frame marker
//   out_valid/out_ready    output handshake
//   out_data               recovered element x (signed)
//   out_last               internally generated end-of-frame tag
//   out_sat                element was clamped to the negative limit
//   frame_err              one-cycle pulse after a mismatched input transfer
module leaky_relu_inv_stream #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FRAC_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] INV_SLOPE  = 32'h0000_6400,
    parameter int                    BATCH_SIZE = 1,
    parameter int                    CHANNELS   = 1,
    parameter int                    HEIGHT     = 4,
    parameter int                    WIDTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_sat,
    output logic                  frame_err
);
    localparam int N     = BATCH_SIZE * CHANNELS * HEIGHT * WIDTH;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    // Pipeline state
    logic                  s1_valid, s2_valid;
    logic [DATA_WIDTH-1:0] s1_y;
    logic                  s1_neg, s1_last;
    logic signed [PW-1:0]  s1_prod;
    logic [CNT_W-1:0]      cnt;

    logic s1_ready, s2_ready, in_fire;
    assign s2_ready  = !s2_valid || out_ready;
    assign s1_ready  = !s1_valid || s2_ready;
    assign in_ready  = s1_ready;
    assign in_fire   = in_valid && s1_ready;
    assign out_valid = s2_valid;

    // Framing. If in_last arrives early, the frame is closed at this element
    // and the counter resyncs. If in_last is missing at the counter's end,
    // the counter still wraps. Either way the tag follows "frame ends here".
    logic at_end, tag_last, mismatch;
    assign at_end   = (cnt == LAST_IDX);
    assign tag_last = at_end || in_last;
    assign mismatch = (in_last != at_end);

    // Explicit sign extension so that the multiply is a true signed
    // 2*DATA_WIDTH product.
    logic signed [PW-1:0] y_ext, k_ext, prod;
    assign y_ext = {{DATA_WIDTH{in_data[DATA_WIDTH-1]}}, in_data};
    assign k_ext = {{DATA_WIDTH{INV_SLOPE[DATA_WIDTH-1]}}, INV_SLOPE};
    assign prod  = y_ext * k_ext;

    // S2 select. A negative product only fits in DATA_WIDTH when every bit
    // from DATA_WIDTH-1 up is a sign copy (all ones). Otherwise it has fallen
    // below the negative limit. It cannot overflow positive because
    // INV_SLOPE > 0.
    logic signed [PW-1:0]  shifted;
    logic                  neg_fits, sat;
    logic [DATA_WIDTH-1:0] x_sel;
    assign shifted  = s1_prod >>> FRAC_WIDTH;
    assign neg_fits = &shifted[PW-1:DATA_WIDTH-1];

    always_comb begin
        sat   = 1'b0;
        x_sel = s1_y;
        if (s1_neg) begin
            if (neg_fits) begin
                x_sel = shifted[DATA_WIDTH-1:0];
            end else begin
                x_sel = {1'b1, {(DATA_WIDTH-1){1'b0}}};
                sat   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            frame_err <= 1'b0;
            s1_valid  <= 1'b0;
            s1_y      <= '0;
            s1_neg    <= 1'b0;
            s1_prod   <= '0;
            s1_last   <= 1'b0;
            s2_valid  <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sat   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (in_fire) begin
                cnt       <= tag_last ? '0 : cnt + CNT_W'(1);
                frame_err <= mismatch;
            end

            // S1 refills in the same cycle that S1 hands its element to S2.
            if (s1_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_y    <= in_data;
                    s1_neg  <= in_data[DATA_WIDTH-1];
                    s1_prod <= prod;
                    s1_last <= tag_last;
                end
            end

            // The output registers only load when S2 can move. This keeps the
            // outputs frozen while the downstream stalls.
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data <= x_sel;
                    out_last <= s1_last;
                    out_sat  <= sat;
                end
            end
        end
    end
endmodule
